// File: rtl/reg_write_back_file.sv
// rtl/reg_write_back_file.sv - RV32I register file with write-back port, clear sweep and retired-write counter
// Optional same-cycle write-to-read bypass: define REG_WRITE_BYPASS_EN.
module reg_write_back_file #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            reg_w_op,
    input  logic [4:0]      reg_w_reg_idx,
    input  logic [XLEN-1:0] reg_w_reg_val,
    input  logic [4:0]      reg_rs1_idx,
    input  logic [4:0]      reg_rs2_idx,
    output logic [XLEN-1:0] reg_rs1_val,
    output logic [XLEN-1:0] reg_rs2_val,
    output logic            ready,
    output logic [31:0]     wb_count
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [4:0]      clear_idx_q, clear_idx_d;
    logic [31:0]     wb_count_q, wb_count_d;
    logic [XLEN-1:0] regs_q [32];
    logic [XLEN-1:0] regs_d [32];
    logic            wr_accept;

    // Writes are only retired once the sweep has finished; x0 is hardwired.
    assign wr_accept = (state_q == ST_RUN) && reg_w_op && (reg_w_reg_idx != 5'd0);

    // The storage array has no reset of its own; the sweep zeroes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            clear_idx_q <= 5'd0;
            wb_count_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            clear_idx_q <= clear_idx_d;
            wb_count_q  <= wb_count_d;
            regs_q      <= regs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (clear_idx_q == 5'd31) state_d = ST_RUN;
            ST_RUN:   state_d = ST_RUN;
            default:  state_d = ST_CLEAR;
        endcase
    end

    always_comb begin
        clear_idx_d = clear_idx_q;
        wb_count_d  = wb_count_q;
        regs_d      = regs_q;
        if (state_q == ST_CLEAR) begin
            regs_d[clear_idx_q] = '0;
            clear_idx_d         = clear_idx_q + 5'd1;
        end else if (wr_accept) begin
            regs_d[reg_w_reg_idx] = reg_w_reg_val;
            wb_count_d            = wb_count_q + 32'd1;
        end
    end

    always_comb begin
        ready       = (state_q == ST_RUN);
        wb_count    = wb_count_q;
        reg_rs1_val = '0;
        reg_rs2_val = '0;
        if (state_q == ST_RUN) begin
            if (reg_rs1_idx != 5'd0) reg_rs1_val = regs_q[reg_rs1_idx];
            if (reg_rs2_idx != 5'd0) reg_rs2_val = regs_q[reg_rs2_idx];
`ifdef REG_WRITE_BYPASS_EN
            if (wr_accept && (reg_w_reg_idx == reg_rs1_idx)) reg_rs1_val = reg_w_reg_val;
            if (wr_accept && (reg_w_reg_idx == reg_rs2_idx)) reg_rs2_val = reg_w_reg_val;
`else
`endif
        end
    end

endmodule

// File: tb/tb_reg_write_back_file.sv
// tb/tb_reg_write_back_file.sv - randomized self-checking bench for reg_write_back_file
module tb_reg_write_back_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_w_op;
    logic [4:0]  reg_w_reg_idx;
    logic [31:0] reg_w_reg_val;
    logic [4:0]  reg_rs1_idx;
    logic [4:0]  reg_rs2_idx;
    logic [31:0] reg_rs1_val;
    logic [31:0] reg_rs2_val;
    logic        ready;
    logic [31:0] wb_count;

    always #5 clk = ~clk;

    reg_write_back_file #(.XLEN(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .reg_w_op      (reg_w_op),
        .reg_w_reg_idx (reg_w_reg_idx),
        .reg_w_reg_val (reg_w_reg_val),
        .reg_rs1_idx   (reg_rs1_idx),
        .reg_rs2_idx   (reg_rs2_idx),
        .reg_rs1_val   (reg_rs1_val),
        .reg_rs2_val   (reg_rs2_val),
        .ready         (ready),
        .wb_count      (wb_count)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    string       phase    = "init";

    // Reference model: architectural register contents, retired-write count,
    // and how many sweep cycles remain before writes are accepted.
    logic [31:0] m_regs [32];
    logic [31:0] m_count;
    int          m_busy;
    bit          m_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s/%s: got %h expected %h", phase, tag, obs, exp);
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] ridx);
        if (m_busy != 0 || ridx == 5'd0) return 32'd0;
`ifdef REG_WRITE_BYPASS_EN
        if (reg_w_op && reg_w_reg_idx != 5'd0 && reg_w_reg_idx == ridx) return reg_w_reg_val;
`endif
        return m_regs[ridx];
    endfunction

    task automatic cycle(input logic r, input logic op, input logic [4:0] widx,
                         input logic [31:0] wval, input logic [4:0] a, input logic [4:0] b);
        @(negedge clk);
        rst           = r;
        reg_w_op      = op;
        reg_w_reg_idx = widx;
        reg_w_reg_val = wval;
        reg_rs1_idx   = a;
        reg_rs2_idx   = b;
        #1;
        if (m_valid) begin
            check("rs1", reg_rs1_val, exp_read(a));
            check("rs2", reg_rs2_val, exp_read(b));
            check("ready", {31'd0, ready}, {31'd0, m_busy == 0});
            check("wb_count", wb_count, m_count);
        end
        if (r) begin
            m_valid = 1'b1;
            m_busy  = 32;
            m_count = 32'd0;
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        end else if (m_busy > 0) begin
            m_busy--;
        end else if (op && widx != 5'd0) begin
            m_regs[widx] = wval;
            m_count++;
        end
    endtask

    task automatic idle(input int n, input logic [4:0] a, input logic [4:0] b);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'd0, 32'd0, a, b);
    endtask

    initial begin
        rst = 1'b1; reg_w_op = 1'b0; reg_w_reg_idx = '0; reg_w_reg_val = '0;
        reg_rs1_idx = '0; reg_rs2_idx = '0;

        phase = "reset";
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd1, 5'd2);
        idle(33, 5'd1, 5'd2);

        phase = "reset_clear";
        cycle(1'b0, 1'b1, 5'd5, 32'h1234, 5'd5, 5'd5);
        idle(1, 5'd5, 5'd5);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
        idle(34, 5'd5, 5'd5);

        phase = "basic";
        cycle(1'b0, 1'b1, 5'd3, 32'hDEADBEEF, 5'd0, 5'd0);
        idle(1, 5'd3, 5'd3);
        check("basic_count", wb_count, 32'd1);

        phase = "x0";
        cycle(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd3);
        idle(1, 5'd0, 5'd0);

        phase = "bypass";
        cycle(1'b0, 1'b1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd3);
        idle(1, 5'd9, 5'd9);

        phase = "rst_with_write";
        cycle(1'b1, 1'b1, 5'd4, 32'h0000BEEF, 5'd4, 5'd4);

        phase = "clear_write";
        for (int i = 1; i <= 32; i++)
            cycle(1'b0, (i == 10), 5'd7, 32'h55, 5'd7, 5'd4);
        idle(2, 5'd7, 5'd4);

        phase = "wrap";
        cycle(1'b0, 1'b1, 5'd2, 32'h2, 5'd2, 5'd2);
        idle(1, 5'd2, 5'd2);
        force dut.wb_count_q = 32'hFFFFFFFF;
        m_count = 32'hFFFFFFFF;
        #1;
        release dut.wb_count_q;
        cycle(1'b0, 1'b1, 5'd6, 32'h66, 5'd6, 5'd2);
        idle(1, 5'd6, 5'd2);
        check("wrap_zero", wb_count, 32'd0);

        phase = "mid_reset";
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd6, 5'd2);
        idle(14, 5'd6, 5'd2);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd6, 5'd2);
        idle(34, 5'd6, 5'd2);

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            logic [4:0] widx;
            logic [4:0] a;
            widx = 5'($urandom_range(0, 31));
            a    = ($urandom_range(0, 3) == 0) ? widx : 5'($urandom_range(0, 31));
            cycle(($urandom_range(0, 149) == 0), 1'($urandom), widx, $urandom,
                  a, 5'($urandom_range(0, 31)));
        end
        idle(34, 5'd1, 5'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
